multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port, the register file and the PC/IR registers over several cycles per instruction.
- Supports the lw, sw, R-type, I-type ALU, beq and jal opcodes.
- Adds a memory ready handshake and an illegal-opcode flag.

Parameters:
- MEM_WAIT_MAX, 15, cycles to wait for mem_ready before asserting mem_timeout; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_code  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_w  out  1  load IR and OldPC
- pc_update  out  1  unconditional PC write
- pc_w  out  1  pc_update | (branch & zero)
- branch  out  1  beq compare cycle
- reg_w  out  1  register file write
- mem_w  out  1  memory write strobe
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 Imm, 10 const 4
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- mem_timeout  out  1  sticky flag, cleared only by rst
- state_o  out  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11-15 are unused and go to FETCH.
- Reset: when rst is high at a clock edge, state becomes FETCH and mem_timeout and the wait counter clear. Reset mid-instruction abandons the instruction; no write strobe may be asserted in the cycle after rst.
- Outputs are Moore, decoded from the state. The exceptions are ir_w, pc_update and mem_w, which are additionally gated by mem_ready. Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_w and pc_update equal mem_ready.
  - Moves to DECODE when mem_ready=1, otherwise holds.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, imm_src=10, alu_op=00 (branch target precompute).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other opcode -> FETCH with illegal_op=1 for that one DECODE cycle.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - imm_src=00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Moves to MEMWB on mem_ready, otherwise holds.
- MEMWB: result_src=01, reg_w=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, result_src=00, mem_w=mem_ready. Moves to FETCH on mem_ready, otherwise holds.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_w=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB (rd <- PC+4).
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, then FETCH. pc_w=zero in this state.
- Latencies with mem_ready tied to 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; illegal opcode 2 cycles.
- Wait counter:
  - 4 bits; counts the cycles mem_req=1 and mem_ready=0.
  - Clears on any completed access or state change.
  - When it reaches MEM_WAIT_MAX (nonzero), mem_timeout sets. The FSM keeps waiting; it does not abort.
  - The counter saturates and does not wrap.
- A mem_ready pulse while mem_req=0 is ignored.

Test Plan:
- rst=1 held for 2 cycles, then 0 -> state_o=0, all strobes 0 during reset; the first FETCH has mem_req=1.
- op_code=0000011, mem_ready=1 constant -> states 0,1,2,3,4,0; reg_w=1 only in state 4 with result_src=01; ir_w=1 only in cycle 0.
- op_code=0100011, mem_ready low for 3 cycles in MEMWRITE -> state_o holds at 5 for 3 cycles; mem_w=1 only in the mem_ready cycle; next state 0.
- op_code=1100011, zero=1, then repeat with zero=0 -> pc_w=1 in BEQ for the first run and 0 for the second; alu_op=01 in both.
- op_code=1111111 -> illegal_op=1 for one cycle in DECODE; back to FETCH; no reg_w or mem_w asserted.
- MEM_WAIT_MAX=15, mem_ready=0 for 20 cycles in FETCH -> mem_timeout rises after 15 waiting cycles and stays 1 after mem_ready; it clears only on rst. Separately, rst asserted in MEMREAD -> next state FETCH with no reg_w.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a small RV32I core: sequences the shared ALU, the unified
// memory port, the register file and PC/IR over several cycles per instruction.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_w,
  output logic       pc_update,
  output logic       pc_w,
  output logic       branch,
  output logic       reg_w,
  output logic       mem_w,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       fetch;
    logic       jal;
    logic       branch;
    logic       reg_w;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
  } ctrl_t;

  state_t     state;
  state_t     next_state;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;
  logic [3:0] wait_cnt;
  logic [3:0] wait_inc;
  logic       legal_op;
  logic       waiting;
  logic       run;

  // Moore decode of a state; registered one cycle early by decoding next_state.
  function automatic ctrl_t decode(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 2'b10; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.imm_src = (op == OP_SW) ? 2'b01 : 2'b00; end
      MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      MEMWB:    begin c.result_src = 2'b01; c.reg_w = 1'b1; end
      MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_w = 1'b1;
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.jal = 1'b1; end
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    legal_op = (op_code == OP_LW) || (op_code == OP_SW) || (op_code == OP_R) ||
               (op_code == OP_I) || (op_code == OP_JAL) || (op_code == OP_BEQ);
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op_code)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op_code == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      JAL:      next_state = ALUWB;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
    ctrl_d = decode(next_state, op_code);
  end

  always_comb begin
    waiting  = mem_req & ~mem_ready;
    wait_inc = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
  end

  // The counter only survives consecutive stalled cycles in one state; timeout never aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      ctrl_q      <= decode(FETCH, op_code);
      wait_cnt    <= 4'd0;
      mem_timeout <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
      if (waiting && (next_state == state)) begin
        wait_cnt <= wait_inc;
        if ((MEM_WAIT_MAX != 0) && (int'(wait_inc) >= MEM_WAIT_MAX))
          mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 4'd0;
      end
    end
  end

  // Strobes are held off while rst is high so an abandoned instruction writes nothing.
  assign run        = ~rst;
  assign mem_req    = ctrl_q.mem_req & run;
  assign adr_src    = ctrl_q.adr_src;
  assign ir_w       = ctrl_q.fetch & mem_ready & run;
  assign pc_update  = ((ctrl_q.fetch & mem_ready) | ctrl_q.jal) & run;
  assign branch     = ctrl_q.branch;
  assign pc_w       = (pc_update | (ctrl_q.branch & zero)) & run;
  assign reg_w      = ctrl_q.reg_w & run;
  assign mem_w      = ctrl_q.mem_write & mem_ready & run;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign imm_src    = ctrl_q.imm_src;
  assign illegal_op = (state == DECODE) & ~legal_op & run;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_w, pc_update, pc_w, branch, reg_w, mem_w;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_o;

  typedef struct {
    logic [23:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .ir_w(ir_w), .pc_update(pc_update),
    .pc_w(pc_w), .branch(branch), .reg_w(reg_w), .mem_w(mem_w),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference output table written from the state descriptions.
  function automatic logic [23:0] expected(input int s, input logic [6:0] op, input logic mr,
                                           input logic z, input logic r, input logic to);
    logic m_req, a_src, irw, pcu, pcw, br, rw, mw, ill;
    logic [1:0] rs, sa, sb_, ao, is;
    m_req = (s == 0) || (s == 3) || (s == 5);
    a_src = (s == 3) || (s == 5);
    irw   = (s == 0) && mr;
    pcu   = ((s == 0) && mr) || (s == 9);
    br    = (s == 10);
    pcw   = pcu || (br && z);
    rw    = (s == 4) || (s == 7);
    mw    = (s == 5) && mr;
    ill   = (s == 1) && !(op == LW || op == SW || op == RT || op == IT || op == JL || op == BQ);
    rs    = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
    sa    = (s == 1 || s == 9) ? 2'b01 : (s == 2 || s == 6 || s == 8 || s == 10) ? 2'b10 : 2'b00;
    sb_   = (s == 0 || s == 9) ? 2'b10 : (s == 1 || s == 2 || s == 8) ? 2'b01 : 2'b00;
    ao    = (s == 6 || s == 8) ? 2'b10 : (s == 10) ? 2'b01 : 2'b00;
    is    = (s == 1) ? 2'b10 : (s == 2 && op == SW) ? 2'b01 : 2'b00;
    if (r) begin
      m_req = 0; irw = 0; pcu = 0; pcw = 0; rw = 0; mw = 0; ill = 0;
    end
    return {4'(s), m_req, a_src, irw, pcu, pcw, br, rw, mw, ill, to, rs, sa, sb_, ao, is};
  endfunction

  task automatic apply_stimulus(input logic r, input logic [6:0] op, input logic mr,
                                input logic z, input int exp_st, input logic exp_to,
                                input string tag);
    sb_entry_t e;
    rst = r; op_code = op; mem_ready = mr; zero = z;
    e.exp = expected(exp_st, op, mr, z, r, exp_to);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input sb_entry_t e);
    logic [23:0] act;
    act = {state_o, mem_req, adr_src, ir_w, pc_update, pc_w, branch, reg_w, mem_w,
           illegal_op, mem_timeout, result_src, alu_src_a, alu_src_b, alu_op, imm_src};
    compared++;
    if (act !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", e.tag, act, e.exp);
    end
  endtask

  initial begin : monitor
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    rst = 1'b1; op_code = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1, LW, 1, 0, 0, 0, "reset0");
    apply_stimulus(1, LW, 1, 0, 0, 0, "reset1");

    for (int i = 0; i < 5; i++) apply_stimulus(0, LW, 1, 0, i, 0, $sformatf("lw_c%0d", i));

    apply_stimulus(0, SW, 1, 0, 0, 0, "sw_fetch");
    apply_stimulus(0, SW, 1, 0, 1, 0, "sw_decode");
    apply_stimulus(0, SW, 1, 0, 2, 0, "sw_memadr");
    for (int i = 0; i < 3; i++) apply_stimulus(0, SW, 0, 0, 5, 0, $sformatf("sw_wait%0d", i));
    apply_stimulus(0, SW, 1, 0, 5, 0, "sw_write");

    apply_stimulus(0, BQ, 1, 1, 0, 0, "beq1_fetch");
    apply_stimulus(0, BQ, 1, 1, 1, 0, "beq1_decode");
    apply_stimulus(0, BQ, 1, 1, 10, 0, "beq1_taken");
    apply_stimulus(0, BQ, 1, 0, 0, 0, "beq0_fetch");
    apply_stimulus(0, BQ, 1, 0, 1, 0, "beq0_decode");
    apply_stimulus(0, BQ, 1, 0, 10, 0, "beq0_not_taken");

    apply_stimulus(0, RT, 1, 0, 0, 0, "r_fetch");
    apply_stimulus(0, RT, 1, 0, 1, 0, "r_decode");
    apply_stimulus(0, RT, 1, 0, 6, 0, "r_exec");
    apply_stimulus(0, RT, 1, 0, 7, 0, "r_wb");
    apply_stimulus(0, IT, 1, 0, 0, 0, "i_fetch");
    apply_stimulus(0, IT, 1, 0, 1, 0, "i_decode");
    apply_stimulus(0, IT, 1, 0, 8, 0, "i_exec");
    apply_stimulus(0, IT, 1, 0, 7, 0, "i_wb");
    apply_stimulus(0, JL, 1, 0, 0, 0, "jal_fetch");
    apply_stimulus(0, JL, 1, 0, 1, 0, "jal_decode");
    apply_stimulus(0, JL, 1, 0, 9, 0, "jal_exec");
    apply_stimulus(0, JL, 1, 0, 7, 0, "jal_wb");

    apply_stimulus(0, BAD, 1, 0, 0, 0, "ill_fetch");
    apply_stimulus(0, BAD, 1, 0, 1, 0, "ill_decode");

    for (int i = 0; i < 20; i++)
      apply_stimulus(0, LW, 0, 0, 0, (i >= 15), $sformatf("to_wait%0d", i));
    apply_stimulus(0, LW, 1, 0, 0, 1, "to_fetch_done");
    apply_stimulus(0, LW, 1, 0, 1, 1, "to_decode");
    apply_stimulus(0, LW, 1, 0, 2, 1, "to_memadr");
    apply_stimulus(1, LW, 1, 0, 3, 1, "rst_in_memread");
    apply_stimulus(0, LW, 1, 0, 0, 0, "after_rst_fetch");
    apply_stimulus(0, LW, 1, 0, 1, 0, "after_rst_decode");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
